// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and types for the memory arbiter
package mem_arbiter_pkg;

  // Default widths, shared with the CPU top
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Owner of the read response due next cycle
  typedef logic [1:0] owner_t;
  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_I    = 2'd1;
  localparam owner_t OWN_D    = 2'd2;

  // Arbiter run state
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// rtl/mem_arbiter_starve_ctr.sv - saturating counter of consecutive refused fetch cycles
module starve_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         at_limit
);

  logic [W-1:0] count;

  // Clear wins over increment; count holds once it reaches the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-ported synchronous-read memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt_req,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [0:0] state;
  owner_t     owner;
  logic       run;
  logic       eligible_i;
  logic       starve;
  logic       starve_inc;

  // Grants only in RUN, out of reset, and not in the cycle halt is requested
  assign run        = rst_n & (state == ST_RUN) & ~halt_req;
  assign eligible_i = i_req & ~i_flush;
  assign i_gnt      = run & eligible_i & (~d_req | starve);
  assign d_gnt      = run & d_req & ~i_gnt;

  // Fetch counts as starved only while it is eligible and refused
  assign starve_inc = run & eligible_i & ~i_gnt;

  starve_ctr #(.W(4)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (starve_inc),
    .clr      (~starve_inc),
    .limit    (4'(STARVE_LIMIT)),
    .at_limit (starve)
  );

  assign mem_en    = i_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = i_gnt ? i_addr : (d_gnt ? d_addr : '0);
  assign mem_wdata = d_gnt ? d_wdata : '0;

  // HALTED is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if ((state == ST_RUN) && halt_req) begin
      state <= ST_HALTED;
    end
  end

  // Remember which port owns the read data arriving next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
    end else if (i_gnt) begin
      owner <= OWN_I;
    end else if (d_gnt && !d_we) begin
      owner <= OWN_D;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign i_rvalid = (owner == OWN_I) & ~i_flush;
  assign d_rvalid = (owner == OWN_D);
  assign i_rdata  = rst_n ? mem_rdata : '0;
  assign d_rdata  = rst_n ? mem_rdata : '0;
  assign halted   = (state == ST_HALTED);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_flush = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [15:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [15:0] d_rdata;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic [15:0] mem [0:65535];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        ig, dg, me, mw;
    logic [15:0] ma, mwd;
    logic        irv, drv;
    logic [15:0] rd;
    logic        hl;
    logic        rst;
  } exp_t;

  exp_t exp_q[$];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .halt_req(halt_req), .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("i_gnt", 16'(i_gnt), 16'(e.ig));
        chk("d_gnt", 16'(d_gnt), 16'(e.dg));
        chk("mem_en", 16'(mem_en), 16'(e.me));
        chk("mem_we", 16'(mem_we), 16'(e.mw));
        chk("mem_addr", mem_addr, e.ma);
        chk("mem_wdata", mem_wdata, e.mwd);
        chk("i_rvalid", 16'(i_rvalid), 16'(e.irv));
        chk("d_rvalid", 16'(d_rvalid), 16'(e.drv));
        chk("halted", 16'(halted), 16'(e.hl));
        if (e.irv) chk("i_rdata", i_rdata, e.rd);
        if (e.drv) chk("d_rdata", d_rdata, e.rd);
        if (e.rst) begin
          chk("i_rdata_rst", i_rdata, 16'h0000);
          chk("d_rdata_rst", d_rdata, 16'h0000);
        end
      end
    end
  end

  // One cycle of stimulus; expected outputs for that cycle go to the scoreboard
  task automatic step(input logic r,
                      input logic ireq, input logic [15:0] iaddr, input logic iflush,
                      input logic dreq, input logic dwe, input logic [15:0] daddr,
                      input logic [15:0] dwdata, input logic hreq,
                      input logic [1:0] eg, input logic [15:0] ema, input logic emw,
                      input logic [1:0] erv, input logic [15:0] erd, input logic ehl);
    exp_t e;
    @(posedge clk);
    #1;
    i_req = ireq; i_addr = iaddr; i_flush = iflush;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
    halt_req = hreq;
    e.ig = eg[1]; e.dg = eg[0]; e.me = |eg; e.mw = emw;
    e.ma = ema; e.mwd = eg[0] ? dwdata : 16'h0000;
    e.irv = erv[1]; e.drv = erv[0]; e.rd = erd; e.hl = ehl; e.rst = ~r;
    exp_q.push_back(e);
    #1;
    rst_n = r;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;

    // reset held with requests active: everything quiet
    step(0, 1,16'h0010,0, 1,0,16'h8000,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    step(0, 1,16'h0010,0, 1,0,16'h8000,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    // single fetch
    step(1, 1,16'h0010,0, 0,0,16'h0,16'h0, 0, 2'b10,16'h0010,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b10,16'h5A4A,0);
    // contention: data 4x, fetch once, then data
    step(1, 1,16'h0020,0, 1,0,16'h8000,16'h0, 0, 2'b01,16'h8000,0, 2'b00,16'h0,0);
    step(1, 1,16'h0020,0, 1,0,16'h8000,16'h0, 0, 2'b01,16'h8000,0, 2'b01,16'hDA5A,0);
    step(1, 1,16'h0020,0, 1,0,16'h8000,16'h0, 0, 2'b01,16'h8000,0, 2'b01,16'hDA5A,0);
    step(1, 1,16'h0020,0, 1,0,16'h8000,16'h0, 0, 2'b01,16'h8000,0, 2'b01,16'hDA5A,0);
    step(1, 1,16'h0020,0, 1,0,16'h8000,16'h0, 0, 2'b10,16'h0020,0, 2'b01,16'hDA5A,0);
    step(1, 1,16'h0020,0, 1,0,16'h8000,16'h0, 0, 2'b01,16'h8000,0, 2'b10,16'h5A7A,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b01,16'hDA5A,0);
    // store then load back
    step(1, 0,16'h0,0, 1,1,16'h0100,16'hBEEF, 0, 2'b01,16'h0100,1, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 1,0,16'h0100,16'h0, 0, 2'b01,16'h0100,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b01,16'hBEEF,0);
    // flush in response cycle, then flush in grant cycle
    step(1, 1,16'h0030,0, 0,0,16'h0,16'h0, 0, 2'b10,16'h0030,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,1, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    step(1, 1,16'h0030,1, 1,0,16'h8000,16'h0, 0, 2'b01,16'h8000,0, 2'b00,16'h0,0);
    // load, then halt: response still delivered, then nothing
    step(1, 0,16'h0,0, 1,0,16'h8000,16'h0, 0, 2'b01,16'h8000,0, 2'b01,16'hDA5A,0);
    step(1, 1,16'h0030,0, 1,0,16'h8000,16'h0, 1, 2'b00,16'h0,0, 2'b01,16'hDA5A,0);
    step(1, 1,16'h0030,0, 1,0,16'h8000,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,1);
    step(1, 1,16'h0030,0, 1,0,16'h8000,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,1);
    // reset leaves HALTED
    step(0, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    // async reset with a fetch response outstanding
    step(1, 1,16'h0010,0, 0,0,16'h0,16'h0, 0, 2'b10,16'h0010,0, 2'b00,16'h0,0);
    step(0, 1,16'h0010,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);
    step(1, 0,16'h0,0, 0,0,16'h0,16'h0, 0, 2'b00,16'h0,0, 2'b00,16'h0,0);

    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
